// File: rtl/parallel2serial.sv
// Parallel-to-serial converter with valid/ready input handshake.
// One pending slot lets a new word follow the current one with no gap.
module parallel2serial #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              data_valid_o,
  output logic              serial_o,
  output logic              first_o,
  output logic              last_o
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic [DATA_W-1:0] pend, pend_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              pend_full, pend_full_n;
  logic              acc;
  logic              last_bit;
  logic              dv_n;
  logic              ser_n;
  logic [DATA_W-1:0] sh_adv;

  assign acc      = valid_i & ready_o;
  assign last_bit = (state == SHIFT) && (cnt == LAST);
  assign sh_adv   = MSB_FIRST ? (sh << 1) : (sh >> 1);

  always_comb begin
    state_n     = state;
    sh_n        = sh;
    pend_n      = pend;
    cnt_n       = cnt;
    pend_full_n = pend_full;
    case (state)
      IDLE: begin
        if (acc) begin
          state_n = SHIFT;
          sh_n    = data_i;
          cnt_n   = '0;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          sh_n  = sh_adv;
          cnt_n = cnt + 1'b1;
          if (acc) begin
            pend_n      = data_i;
            pend_full_n = 1'b1;
          end
        end else if (pend_full) begin
          sh_n        = pend;
          pend_n      = '0;
          pend_full_n = 1'b0;
          cnt_n       = '0;
        end else if (acc) begin
          // bypass: word arriving on the last bit goes straight in
          sh_n  = data_i;
          cnt_n = '0;
        end else begin
          state_n = IDLE;
          sh_n    = '0;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign dv_n  = (state_n == SHIFT);
  assign ser_n = dv_n & (MSB_FIRST ? sh_n[DATA_W-1] : sh_n[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sh           <= '0;
      pend         <= '0;
      cnt          <= '0;
      pend_full    <= 1'b0;
      ready_o      <= 1'b0;
      data_valid_o <= 1'b0;
      serial_o     <= 1'b0;
      first_o      <= 1'b0;
      last_o       <= 1'b0;
    end else begin
      state        <= state_n;
      sh           <= sh_n;
      pend         <= pend_n;
      cnt          <= cnt_n;
      pend_full    <= pend_full_n;
      ready_o      <= ~pend_full_n;
      data_valid_o <= dv_n;
      serial_o     <= ser_n;
      first_o      <= dv_n && (cnt_n == '0);
      last_o       <= dv_n && (cnt_n == LAST);
    end
  end

endmodule

// File: tb/tb_parallel2serial.sv
// Bench for parallel2serial: MSB-first and LSB-first instances share stimulus,
// a scoreboard rebuilds each word from the serial stream.
module tb_parallel2serial;

  logic       clk;
  logic       rst_n;
  logic       valid;
  logic [7:0] data;

  logic rdy_m, dv_m, ser_m, fst_m, lst_m;
  logic rdy_l, dv_l, ser_l, fst_l, lst_l;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_m[$];
  logic [7:0] q_l[$];

  int         cnt_m = 0;
  int         cnt_l = 0;
  logic [7:0] acc_m = '0;
  logic [7:0] acc_l = '0;
  int         run_m = 0;
  int         last_run = 0;

  parallel2serial dut_m (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .data_i(data),
    .ready_o(rdy_m), .data_valid_o(dv_m), .serial_o(ser_m),
    .first_o(fst_m), .last_o(lst_m)
  );

  parallel2serial #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .data_i(data),
    .ready_o(rdy_l), .data_valid_o(dv_l), .serial_o(ser_l),
    .first_o(fst_l), .last_o(lst_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // MSB-first stream rebuilt as a left-shift, bit-in-LSB receiver
  always @(negedge clk) begin
    if (!rst_n) begin
      cnt_m = 0;
      run_m = 0;
      q_m.delete();
    end else if (dv_m) begin
      chk("m_first", fst_m, cnt_m == 0);
      chk("m_last", lst_m, cnt_m == 7);
      acc_m = {acc_m[6:0], ser_m};
      run_m++;
      if (cnt_m == 7) begin
        if (q_m.size() == 0) chk("m_extra_word", 1, 0);
        else chk("m_word", acc_m, q_m.pop_front());
        cnt_m = 0;
      end else cnt_m++;
    end else begin
      chk("m_idle_out", {ser_m, fst_m, lst_m}, 0);
      chk("m_gap_midword", cnt_m, 0);
      if (run_m != 0) last_run = run_m;
      run_m = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      cnt_l = 0;
      q_l.delete();
    end else if (dv_l) begin
      chk("l_first", fst_l, cnt_l == 0);
      chk("l_last", lst_l, cnt_l == 7);
      acc_l = {ser_l, acc_l[7:1]};
      if (cnt_l == 7) begin
        if (q_l.size() == 0) chk("l_extra_word", 1, 0);
        else chk("l_word", acc_l, q_l.pop_front());
        cnt_l = 0;
      end else cnt_l++;
    end else begin
      chk("l_idle_out", {ser_l, fst_l, lst_l}, 0);
      chk("l_gap_midword", cnt_l, 0);
    end
  end

  // called at a negedge; returns at the negedge after the handshake edge
  task automatic send(input logic [7:0] w);
    valid = 1'b1;
    data  = w;
    for (int i = 0; i < 64; i++) begin
      if (rdy_m) begin
        chk("ready_pair", rdy_l, 1);
        q_m.push_back(w);
        q_l.push_back(w);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    chk("send_timeout", 1, 0);
  endtask

  logic seen;

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    data  = '0;

    @(negedge clk);
    chk("rst_outs_m", {rdy_m, dv_m, ser_m, fst_m, lst_m}, 0);
    chk("rst_outs_l", {rdy_l, dv_l, ser_l, fst_l, lst_l}, 0);
    #1 rst_n = 1'b1;
    #1 chk("ready_before_edge", rdy_m, 0);
    @(negedge clk);
    chk("ready_after_rst", rdy_m, 1);

    // single word, latency 1
    send(8'hA5);
    valid = 1'b0;
    chk("a5_lat_dv", dv_m, 1);
    chk("a5_lat_first", fst_m, 1);
    chk("a5_lat_ser_m", ser_m, 1);
    chk("a5_lat_ser_l", ser_l, 1);
    repeat (10) @(negedge clk);
    chk("a5_done_dv", dv_m, 0);

    send(8'h01);
    valid = 1'b0;
    chk("w01_ser_m", ser_m, 0);
    chk("w01_ser_l", ser_l, 1);
    repeat (10) @(negedge clk);

    // back-to-back with valid held high
    send(8'hA5);
    send(8'h3C);
    chk("b2b_ready_low", rdy_m, 0);
    send(8'hFF);
    valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("b2b_run_len", last_run, 24);

    // bypass on the last bit
    send(8'hA5);
    valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("byp_last", lst_m, 1);
    chk("byp_ready", rdy_m, 1);
    send(8'h5A);
    valid = 1'b0;
    chk("byp_first", fst_m, 1);
    chk("byp_dv", dv_m, 1);
    chk("byp_ser_m", ser_m, 0);
    repeat (12) @(negedge clk);
    chk("byp_run_len", last_run, 16);

    // reset mid-word with a pending word
    send(8'hA5);
    send(8'h3C);
    valid = 1'b0;
    chk("rst_pend_ready", rdy_m, 0);
    repeat (2) @(negedge clk);
    chk("rst_bit4_dv", dv_m, 1);
    #1 rst_n = 1'b0;
    #1 chk("async_rst_m", {rdy_m, dv_m, ser_m, fst_m, lst_m}, 0);
    chk("async_rst_l", {rdy_l, dv_l, ser_l, fst_l, lst_l}, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 chk("rel_ready_pre", rdy_m, 0);
    @(negedge clk);
    chk("rel_ready_post", rdy_m, 1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | dv_m | dv_l;
    end
    chk("no_resume", seen, 0);

    // random loopback
    for (int i = 0; i < 256; i++) begin
      send(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) begin
        valid = 1'b0;
        repeat ($urandom_range(1, 10)) @(negedge clk);
      end
    end
    valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("rand_drain_m", q_m.size(), 0);
    chk("rand_drain_l", q_l.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
